// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline controller.
package pipe_ctrl_pkg;

  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV      = 2'd1,
    EXC_PEND = 2'd2
  } pc_state_t;

  typedef struct packed {
    logic pc_wr;
    logic id_wr;
    logic exe_wr;
    logic mem_wr;
    logic id_flush;
    logic exe_flush;
    logic mem_flush;
    logic wb_flush;
  } stage_ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam stage_ctrl_t CTRL_ADVANCE = '{
    pc_wr: 1'b1, id_wr: 1'b1, exe_wr: 1'b1, mem_wr: 1'b1,
    id_flush: 1'b0, exe_flush: 1'b0, mem_flush: 1'b0, wb_flush: 1'b0
  };

  // Held in reset: no stage loads, every stage register takes a bubble.
  localparam stage_ctrl_t CTRL_RESET = '{
    pc_wr: 1'b0, id_wr: 1'b0, exe_wr: 1'b0, mem_wr: 1'b0,
    id_flush: 1'b1, exe_flush: 1'b1, mem_flush: 1'b1, wb_flush: 1'b1
  };

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush arbiter with a small FSM for multi-cycle divides and
// exception redirects that must wait out an in-flight I-cache fill.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic ID_StallReq,
  input  logic IF_ICacheBusy,
  input  logic EXE_DivStart,
  input  logic MEM_DCacheBusy,
  input  logic MEM_ExcValid,
  output logic PC_Wr,
  output logic ID_Wr,
  output logic EXE_Wr,
  output logic MEM_Wr,
  output logic ID_Flush,
  output logic EXE_Flush,
  output logic MEM_Flush,
  output logic WB_Flush,
  output logic PC_Redirect,
  output logic Div_Busy,
  output logic Div_Abort
);

  localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

  pc_state_t             state;
  logic [DIV_CNT_W-1:0]  cnt;
  stage_ctrl_t           ctrl;
  logic                  redirect;
  logic                  abort;
  logic                  div_hold;

  // NOTE: registered state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge value of state/cnt regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (MEM_ExcValid) begin
      state <= IF_ICacheBusy ? EXC_PEND : RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          // The divider runs on its own, so a start is taken even if MEM stalls.
          if (EXE_DivStart) begin
            state <= DIV;
            cnt   <= DIV_LOAD;
          end
        end
        DIV: begin
          if (cnt != '0)
            cnt <= cnt - 1'b1;
          else if (!MEM_DCacheBusy)
            state <= RUN;
        end
        EXC_PEND: begin
          if (!IF_ICacheBusy)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Divide in progress (or just issued) and result not yet valid in EXE.
  assign div_hold = ((state == DIV) && (cnt != '0)) ||
                    ((state == RUN) && EXE_DivStart);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ctrl     = CTRL_ADVANCE;
    redirect = 1'b0;
    abort    = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (MEM_ExcValid) begin
      ctrl.pc_wr     = !IF_ICacheBusy;
      ctrl.id_flush  = 1'b1;
      ctrl.exe_flush = 1'b1;
      ctrl.mem_flush = 1'b1;
      redirect       = !IF_ICacheBusy;
      abort          = (state == DIV);
    end else if (state == EXC_PEND) begin
      // MEM already holds a bubble here, so a D-cache stall has nothing to hold.
      ctrl.id_flush = 1'b1;
      if (IF_ICacheBusy) begin
        ctrl.pc_wr     = 1'b0;
        ctrl.exe_flush = 1'b1;
      end else begin
        redirect = 1'b1;
      end
    end else if (MEM_DCacheBusy) begin
      ctrl.pc_wr    = 1'b0;
      ctrl.id_wr    = 1'b0;
      ctrl.exe_wr   = 1'b0;
      ctrl.mem_wr   = 1'b0;
      ctrl.wb_flush = 1'b1;
    end else if (div_hold) begin
      ctrl.pc_wr     = 1'b0;
      ctrl.id_wr     = 1'b0;
      ctrl.exe_wr    = 1'b0;
      ctrl.mem_flush = 1'b1;
    end else if (state == DIV) begin
      ctrl = CTRL_ADVANCE;
    end else if (ID_StallReq) begin
      ctrl.pc_wr     = 1'b0;
      ctrl.id_wr     = 1'b0;
      ctrl.exe_flush = 1'b1;
    end else if (IF_ICacheBusy) begin
      ctrl.pc_wr    = 1'b0;
      ctrl.id_flush = 1'b1;
    end
  end

  assign PC_Wr       = ctrl.pc_wr;
  assign ID_Wr       = ctrl.id_wr;
  assign EXE_Wr      = ctrl.exe_wr;
  assign MEM_Wr      = ctrl.mem_wr;
  assign ID_Flush    = ctrl.id_flush;
  assign EXE_Flush   = ctrl.exe_flush;
  assign MEM_Flush   = ctrl.mem_flush;
  assign WB_Flush    = ctrl.wb_flush;
  assign PC_Redirect = redirect;
  assign Div_Abort   = abort;
  assign Div_Busy    = !rst && (state == DIV);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each cycle's outputs are compared against a
// hand-computed 11-bit vector {Wr x4, Flush x4, PC_Redirect, Div_Busy, Div_Abort}.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic ID_StallReq, IF_ICacheBusy, EXE_DivStart, MEM_DCacheBusy, MEM_ExcValid;
  logic PC_Wr, ID_Wr, EXE_Wr, MEM_Wr;
  logic ID_Flush, EXE_Flush, MEM_Flush, WB_Flush;
  logic PC_Redirect, Div_Busy, Div_Abort;
  logic [10:0] obs;

  int checks   = 0;
  int failures = 0;

  // Order: pc id exe mem wr | id exe mem wb flush | redirect busy abort
  localparam logic [10:0] V_RESET    = 11'b0000_1111_000;
  localparam logic [10:0] V_IDLE     = 11'b1111_0000_000;
  localparam logic [10:0] V_STALL    = 11'b0011_0100_000;
  localparam logic [10:0] V_ICB      = 11'b0111_1000_000;
  localparam logic [10:0] V_DC_RUN   = 11'b0000_0001_000;
  localparam logic [10:0] V_DIV_ISS  = 11'b0001_0010_000;
  localparam logic [10:0] V_DIV_CNT  = 11'b0001_0010_010;
  localparam logic [10:0] V_DIV_DC   = 11'b0000_0001_010;
  localparam logic [10:0] V_DIV_END  = 11'b1111_0000_010;
  localparam logic [10:0] V_EXC_RUN  = 11'b1111_1110_100;
  localparam logic [10:0] V_EXC_FILL = 11'b0111_1110_000;
  localparam logic [10:0] V_PEND     = 11'b0111_1100_000;
  localparam logic [10:0] V_PEND_OUT = 11'b1111_1000_100;
  localparam logic [10:0] V_EXC_DIV  = 11'b1111_1110_111;

  pipe_ctrl #(.DIV_CYCLES(36)) dut (
    .clk(clk), .rst(rst),
    .ID_StallReq(ID_StallReq), .IF_ICacheBusy(IF_ICacheBusy),
    .EXE_DivStart(EXE_DivStart), .MEM_DCacheBusy(MEM_DCacheBusy),
    .MEM_ExcValid(MEM_ExcValid),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr),
    .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush),
    .WB_Flush(WB_Flush), .PC_Redirect(PC_Redirect),
    .Div_Busy(Div_Busy), .Div_Abort(Div_Abort)
  );

  always #5 clk = ~clk;

  assign obs = {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, ID_Flush, EXE_Flush, MEM_Flush,
                WB_Flush, PC_Redirect, Div_Busy, Div_Abort};

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic stall, input logic icb, input logic dstart,
                       input logic dcb, input logic exc);
    ID_StallReq    = stall;
    IF_ICacheBusy  = icb;
    EXE_DivStart   = dstart;
    MEM_DCacheBusy = dcb;
    MEM_ExcValid   = exc;
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later,
  // well before the next rising edge.
  task automatic step(input string tag, input logic [10:0] exp);
    #2;
    check(tag, obs, exp);
    @(negedge clk);
  endtask

  task automatic div_issue_and_count(input int n);
    drive(0, 0, 1, 0, 0);
    step("div_issue", V_DIV_ISS);
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= n; k++) step("div_count", V_DIV_CNT);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step("reset_idle_inputs", V_RESET);
    drive(1, 1, 1, 1, 1);
    step("reset_busy_inputs", V_RESET);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;

    step("idle_after_reset", V_IDLE);
    step("idle_second", V_IDLE);

    // Load-use stall for exactly one cycle.
    drive(1, 0, 0, 0, 0);
    step("load_use", V_STALL);
    drive(0, 0, 0, 0, 0);
    step("load_use_release", V_IDLE);

    // I-cache busy alone, then combined with an ID stall (ID holds, no flush).
    drive(0, 1, 0, 0, 0);
    step("icache_busy", V_ICB);
    drive(1, 1, 0, 0, 0);
    step("stall_plus_icache", V_STALL);
    drive(0, 0, 0, 1, 0);
    step("dcache_run", V_DC_RUN);
    drive(1, 1, 0, 1, 0);
    step("dcache_over_stall", V_DC_RUN);
    drive(0, 0, 0, 0, 0);
    step("idle_pre_div", V_IDLE);

    // Plain divide: EXE held 36 cycles including the issue cycle; a second
    // start pulse while busy is ignored.
    drive(0, 0, 1, 0, 0);
    step("div_issue", V_DIV_ISS);
    for (int k = 1; k <= 35; k++) begin
      drive(0, 0, (k == 5), 0, 0);
      step("div_count", V_DIV_CNT);
    end
    drive(0, 0, 0, 0, 0);
    step("div_result", V_DIV_END);
    step("div_back_run", V_IDLE);

    // Divide overlapped by D-cache busy on cycles 34..40; counter keeps
    // running, so DIV completes on cycle 41.
    div_issue_and_count(33);
    for (int k = 34; k <= 40; k++) begin
      drive(0, 0, 0, 1, 0);
      step("div_dcache", V_DIV_DC);
    end
    drive(0, 0, 0, 0, 0);
    step("div_dcache_exit", V_DIV_END);
    step("div_dcache_run", V_IDLE);

    // Exception during an I-cache fill, with a D-cache stall ignored in EXC_PEND.
    drive(0, 1, 0, 0, 1);
    step("exc_fill", V_EXC_FILL);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0, (k == 3), 0);
      step("exc_pend", V_PEND);
    end
    drive(0, 0, 0, 0, 0);
    step("exc_pend_redirect", V_PEND_OUT);
    step("exc_pend_run", V_IDLE);

    // Exception in RUN with I-cache idle.
    drive(0, 0, 0, 0, 1);
    step("exc_run", V_EXC_RUN);
    drive(0, 0, 0, 0, 0);
    step("exc_run_after", V_IDLE);

    // Exception aborts a divide on cycle 10.
    div_issue_and_count(9);
    drive(0, 0, 0, 0, 1);
    step("div_abort", V_EXC_DIV);
    drive(0, 0, 0, 0, 0);
    step("div_abort_run", V_IDLE);

    // Reset mid-divide: no abort, back in RUN.
    div_issue_and_count(3);
    rst = 1'b1;
    step("reset_mid_div", V_RESET);
    rst = 1'b0;
    step("after_reset_div", V_IDLE);

    // Reset mid-EXC_PEND: once released, no pending redirect remains.
    drive(0, 1, 0, 0, 1);
    step("exc_fill_2", V_EXC_FILL);
    drive(0, 1, 0, 0, 0);
    step("exc_pend_2", V_PEND);
    rst = 1'b1;
    step("reset_mid_pend", V_RESET);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    step("after_reset_pend", V_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
